// File: rtl/voice_recv_cache.sv
// Receive-side voice cache: packs bytes into PCM samples, buffers them, plays them out after a prefill.
// Defining VOICE_RX_STATS_EN adds saturating counters ovf_cnt, udf_cnt and pkt_cnt.
module voice_recv_cache #(
  parameter int ADDR_W  = 10,
  parameter int PREFILL = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            voice_vsync,
  input  logic            voice_href,
  input  logic [7:0]      ldata_in,
  input  logic            sample_req,
  output logic [15:0]     ldata_out,
  output logic            sample_valid,
  output logic [ADDR_W:0] level,
  output logic            playing,
  output logic            overflow,
`ifdef VOICE_RX_STATS_EN
  output logic            underflow,
  output logic [15:0]     ovf_cnt,
  output logic [15:0]     udf_cnt,
  output logic [15:0]     pkt_cnt
`else
  output logic            underflow
`endif
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] PRE_LVL = (ADDR_W+1)'(PREFILL);
  localparam logic [ADDR_W:0] LVL_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic {S_FILL, S_PLAY} state_e;

  state_e            state_q, state_d;
  logic              vsync_q;
  logic              phase_q, phase_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [15:0]       ldata_q, ldata_d;
  logic              valid_q, valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              vs_rise, wr_req, wr_do, rd_do;
  logic              full, empty;
  logic [15:0]       mem [DEPTH];

  assign vs_rise = voice_vsync & ~vsync_q;
  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign wr_do   = wr_req & ~full;

  // A packet start discards any held high byte before the current byte is looked at.
  always_comb begin
    phase_d = phase_q;
    hi_d    = hi_q;
    wr_req  = 1'b0;
    if (vs_rise) phase_d = 1'b0;
    if (voice_href) begin
      if (vs_rise || !phase_q) begin
        hi_d    = ldata_in;
        phase_d = 1'b1;
      end else begin
        wr_req  = 1'b1;
        phase_d = 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ldata_d = ldata_q;
    valid_d = 1'b0;
    udf_d   = 1'b0;
    rd_do   = 1'b0;
    ovf_d   = wr_req & full;
    unique case (state_q)
      S_FILL: begin
        if (sample_req) begin
          ldata_d = '0;
          valid_d = 1'b1;
        end
        if (level_q >= PRE_LVL) state_d = S_PLAY;
      end
      S_PLAY: begin
        if (sample_req) begin
          valid_d = 1'b1;
          if (empty) begin
            ldata_d = '0;
            udf_d   = 1'b1;
            state_d = S_FILL;
          end else begin
            ldata_d = mem[rd_ptr_q];
            rd_do   = 1'b1;
          end
        end
      end
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_do ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_do ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    unique case ({wr_do, rd_do})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_do) mem[wr_ptr_q] <= {hi_q, ldata_in};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FILL;
      vsync_q  <= 1'b0;
      phase_q  <= 1'b0;
      hi_q     <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ldata_q  <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      vsync_q  <= voice_vsync;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ldata_q  <= ldata_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  assign ldata_out    = ldata_q;
  assign sample_valid = valid_q;
  assign level        = level_q;
  assign playing      = (state_q == S_PLAY);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

`ifdef VOICE_RX_STATS_EN
  logic [15:0] ovf_cnt_q, udf_cnt_q, pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_cnt_q <= '0;
      udf_cnt_q <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (ovf_d && ovf_cnt_q != 16'hFFFF) ovf_cnt_q <= ovf_cnt_q + 16'd1;
      if (udf_d && udf_cnt_q != 16'hFFFF) udf_cnt_q <= udf_cnt_q + 16'd1;
      if (vs_rise && pkt_cnt_q != 16'hFFFF) pkt_cnt_q <= pkt_cnt_q + 16'd1;
    end
  end

  assign ovf_cnt = ovf_cnt_q;
  assign udf_cnt = udf_cnt_q;
  assign pkt_cnt = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_voice_recv_cache.sv
// Bench for voice_recv_cache: directed steps plus random traffic against a queue-based model.
// Stats counters are checked when VOICE_RX_STATS_EN is defined.
module tb_voice_recv_cache;
  localparam int DEPTH = 1024;
  localparam int PRE   = 256;

  logic        clk = 1'b0;
  logic        rst, vs, hr, rq;
  logic [7:0]  din;
  logic [15:0] dout;
  logic        vld, ply, ovf, udf;
  logic [10:0] lvl;
`ifdef VOICE_RX_STATS_EN
  logic [15:0] ovc, udc, pkc;
`endif

  always #5 clk = ~clk;

  voice_recv_cache #(.ADDR_W(10), .PREFILL(PRE)) dut (
    .clk(clk),
    .rst(rst),
    .voice_vsync(vs),
    .voice_href(hr),
    .ldata_in(din),
    .sample_req(rq),
    .ldata_out(dout),
    .sample_valid(vld),
    .level(lvl),
    .playing(ply),
    .overflow(ovf),
`ifdef VOICE_RX_STATS_EN
    .underflow(udf),
    .ovf_cnt(ovc),
    .udf_cnt(udc),
    .pkt_cnt(pkc)
`else
    .underflow(udf)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a FIFO of samples plus a play flag.
  int          q[$];
  bit          m_hiv, m_pvs, m_play, m_vld, m_ovf, m_udf;
  logic [7:0]  m_hi;
  logic [15:0] m_out;
  int          m_ovc, m_udc, m_pkc;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_hiv = 0; m_pvs = 0; m_play = 0;
    m_vld = 0; m_ovf = 0; m_udf = 0;
    m_hi = '0; m_out = '0;
    m_ovc = 0; m_udc = 0; m_pkc = 0;
  endtask

  task automatic model_step();
    int          l0;
    bit          rise, wr, nxt;
    logic [15:0] s;
    l0   = q.size();
    rise = vs && !m_pvs;
    m_pvs = vs;
    wr = 0;
    s  = '0;
    if (rise) begin
      m_hiv = 0;
      if (m_pkc < 16'hFFFF) m_pkc++;
    end
    if (hr) begin
      if (!m_hiv) begin
        m_hi  = din;
        m_hiv = 1;
      end else begin
        s     = {m_hi, din};
        wr    = 1;
        m_hiv = 0;
      end
    end
    nxt   = m_play;
    m_vld = rq;
    m_udf = 0;
    m_ovf = 0;
    if (!m_play && l0 >= PRE) nxt = 1;
    if (rq) begin
      if (m_play && l0 > 0) m_out = 16'(q.pop_front());
      else begin
        m_out = '0;
        if (m_play) begin
          m_udf = 1;
          nxt   = 0;
          if (m_udc < 16'hFFFF) m_udc++;
        end
      end
    end
    if (wr) begin
      if (l0 >= DEPTH) begin
        m_ovf = 1;
        if (m_ovc < 16'hFFFF) m_ovc++;
      end else q.push_back(int'(s));
    end
    m_play = nxt;
  endtask

  task automatic check_all();
    chk("ldata_out", dout, m_out);
    chk("sample_valid", vld, m_vld);
    chk("level", lvl, q.size());
    chk("playing", ply, m_play);
    chk("overflow", ovf, m_ovf);
    chk("underflow", udf, m_udf);
`ifdef VOICE_RX_STATS_EN
    chk("ovf_cnt", ovc, m_ovc);
    chk("udf_cnt", udc, m_udc);
    chk("pkt_cnt", pkc, m_pkc);
`endif
  endtask

  task automatic check_reset_vals(string tag);
    chk({tag, "_ldata"}, dout, 0);
    chk({tag, "_valid"}, vld, 0);
    chk({tag, "_level"}, lvl, 0);
    chk({tag, "_playing"}, ply, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_udf"}, udf, 0);
`ifdef VOICE_RX_STATS_EN
    chk({tag, "_ovc"}, ovc, 0);
    chk({tag, "_udc"}, udc, 0);
    chk({tag, "_pkc"}, pkc, 0);
`endif
  endtask

  task automatic step(bit h, logic [7:0] d, bit r);
    hr  = h;
    din = d;
    rq  = r;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic send(logic [15:0] s);
    step(1'b1, s[15:8], 1'b0);
    step(1'b1, s[7:0], 1'b0);
  endtask

  initial begin
    logic [15:0] s;
    rst = 1'b1; vs = 1'b0; hr = 1'b0; rq = 1'b0; din = '0;
    model_reset();
    #2;
    check_reset_vals("por");
    #10;
    rst = 1'b0;

    // Request while filling: zero sample, no underflow.
    step(1'b0, 8'h00, 1'b1);
    chk("fill_req_valid", vld, 1);
    chk("fill_req_udf", udf, 0);
    step(1'b0, 8'h00, 1'b0);

    // Packet of 256 samples starting at 0x0028.
    vs = 1'b1;
    for (int i = 0; i < 256; i++) send(16'(16'h0028 + i));
    chk("prefill_level", lvl, 256);
    step(1'b0, 8'h00, 1'b0);
    chk("prefill_playing", ply, 1);
    step(1'b0, 8'h00, 1'b1);
    chk("first_read", dout, 16'h0028);
    step(1'b0, 8'h00, 1'b1);
    chk("second_read", dout, 16'h0029);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, i[0]);

    // Partial sample discarded by a new packet.
    vs = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'hAA, 1'b0);
    vs = 1'b1;
    step(1'b1, 8'hBB, 1'b0);
    step(1'b1, 8'hCC, 1'b0);

    // Simultaneous write and read at level 300.
    while (q.size() < 300) send(16'($urandom));
    chk("lvl300", lvl, 300);
    step(1'b1, 8'h5A, 1'b0);
    step(1'b1, 8'hA5, 1'b1);
    chk("lvl300_same", lvl, 300);

    // Fill to the top, then two dropped samples.
    while (q.size() < DEPTH) send(16'($urandom));
    chk("full_level", lvl, DEPTH);
    for (int i = 0; i < 2; i++) begin
      s = 16'($urandom);
      step(1'b1, s[15:8], 1'b0);
      step(1'b1, s[7:0], 1'b0);
      chk("ovf_pulse", ovf, 1);
    end
    chk("full_level2", lvl, DEPTH);

    // Drain everything, then one request too many.
    for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1);
    chk("drained", lvl, 0);
    step(1'b0, 8'h00, 1'b1);
    chk("udf_pulse", udf, 1);
    chk("udf_data", dout, 0);
    chk("udf_playing", ply, 0);

    // Refill across the pointer wrap and read back.
    for (int i = 0; i < PRE; i++) send(16'($urandom));
    step(1'b0, 8'h00, 1'b0);
    chk("refill_playing", ply, 1);
    for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b1);

    // Reset mid-packet at level 100.
    while (q.size() > 100) step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h77, 1'b0);
    chk("pre_rst_level", lvl, 100);
`ifdef VOICE_RX_STATS_EN
    chk("pre_rst_ovc", ovc, 2);
    chk("pre_rst_udc", udc, 1);
`endif
    #2;
    rst = 1'b1;
    vs  = 1'b0;
    hr  = 1'b0;
    #1;
    check_reset_vals("async_rst");
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;

    // Random traffic: filling phase then draining phase.
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(63) == 0) vs = ~vs;
      step(1'($urandom_range(1)), 8'($urandom),
           (i < 3000) ? ($urandom_range(5) == 0) : ($urandom_range(2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/voice_recv_cache.md
Name: voice_recv_cache

Overview:
- Receive-side counterpart of the voice transmit cache.
- Accepts the byte stream recovered from the Ethernet receive path: voice_vsync marks a packet start, voice_href qualifies each 8-bit byte.
- Re-packs byte pairs into 16-bit PCM samples, buffers them in a circular sample FIFO, and releases one sample per DAC/I2S sample request.
- Playback starts only after a prefill threshold is reached, which absorbs network jitter.

Parameters:
- ADDR_W, 10, log2 of sample buffer depth (1024 samples).
- PREFILL, 256, buffered-sample count required before playback starts or resumes; must be ≥ 1 and ≤ 2^ADDR_W.

Ports:
- clk  input  1  single system clock; all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- voice_vsync  input  1  packet framing; a rising edge marks a new packet start.
- voice_href  input  1  byte valid.
- ldata_in  input  8  received byte; high byte of each sample first.
- sample_req  input  1  one-cycle pulse from the playback side, once per LRCK period.
- ldata_out  output  16  sample to DAC; held between requests.
- sample_valid  output  1  one-cycle pulse; ldata_out updated.
- level  output  ADDR_W+1  samples currently buffered.
- playing  output  1  high in PLAY state.
- overflow  output  1  one-cycle pulse; a completed sample was dropped because the buffer was full.
- underflow  output  1  one-cycle pulse; a request arrived in PLAY with the buffer empty.

Behaviour:
- Reset values:
  - ldata_out = 0, sample_valid = 0, level = 0, playing = 0, overflow = 0, underflow = 0.
  - Write and read pointers = 0.
  - byte_phase = 0, state = FILL.
  - Registered vsync = 0.
- Reset is asynchronous at any time. Mid-packet or mid-playback, all buffered data is discarded and the partial byte is lost.
- Byte packing:
  - vsync edge detect: vsync_d registered each cycle; edge = voice_vsync & ~vsync_d.
  - On edge, byte_phase is cleared and any held high byte is discarded.
  - voice_href with byte_phase = 0: store ldata_in as the high byte, set byte_phase = 1.
  - voice_href with byte_phase = 1: form {hi, ldata_in}, issue a write, clear byte_phase.
  - Edge and href in the same cycle: edge applies first, and the byte is taken as the high byte of a new sample.
  - href low: no change; gaps between bytes are allowed.
- Write:
  - If level < 2^ADDR_W, the sample is written at wr_ptr and wr_ptr increments, wrapping modulo 2^ADDR_W.
  - If full, the sample is dropped, overflow pulses for 1 cycle, and pointers are unchanged.
- Read and output state machine:
  - FILL:
    - sample_req → ldata_out = 0 and sample_valid pulses on the next cycle; no FIFO read, no underflow.
    - Transition to PLAY when level ≥ PREFILL, evaluated on the registered level.
  - PLAY:
    - sample_req with level > 0 → next cycle ldata_out = mem[rd_ptr] and sample_valid = 1; rd_ptr increments with wrap.
    - sample_req with level = 0 → next cycle ldata_out = 0, sample_valid = 1, underflow = 1, state → FILL.
- Latency: sample_req at cycle N gives ldata_out/sample_valid at N+1. A write at cycle N is visible to a read at N+1 or later.
- level:
  - Write only: +1. Read only: −1.
  - Write and read in the same cycle: unchanged; both operations are performed.
  - level is never negative and never exceeds 2^ADDR_W.
- Memory may be inferred as distributed RAM with async read feeding the ldata_out register, or as block RAM with a read-ahead register. The 1-cycle latency is mandatory either way.

Optional Feature:
- Macro: VOICE_RX_STATS_EN.
- Defined:
  - Adds outputs ovf_cnt[15:0], udf_cnt[15:0] and pkt_cnt[15:0].
  - ovf_cnt counts overflow pulses, udf_cnt counts underflow pulses, pkt_cnt counts vsync rising edges.
  - All counters saturate at 16'hFFFF and reset to 0 on rst.
- Undefined: these ports and counters do not exist; core behaviour is identical.

Test Plan:
- Reset held, then released; ldata_out = 0, level = 0, playing = 0. Issue sample_req → sample_valid pulses with ldata_out = 0 and no underflow.
- vsync edge, then 512 href bytes carrying samples 16'h0028 upward (bytes 00,28,00,29,…) → level = 256 and playing = 1 after the 256th sample. Subsequent requests return 0x0028, 0x0029… in order, 1 cycle after each request.
- Partial sample: bytes AA, vsync edge, BB, CC → stored sample 16'hBBCC; AA discarded.
- Write and sample_req in the same cycle with level = 300 → level stays 300; output equals the oldest sample.
- Fill with 1024 samples without requests, then 2 more samples → level = 1024, two overflow pulses, and the first read returns sample #0. Drain all 1024, then one more request → ldata_out = 0, underflow pulses, playing = 0. Refill 256 → playing = 1, with correct data across pointer wrap.
- Assert rst mid-packet with level = 100 → all outputs return to reset values immediately. With VOICE_RX_STATS_EN defined, ovf_cnt = 2, udf_cnt = 1 and pkt_cnt = number of vsync edges seen before reset; all counters read 0 after it.
